// File: rtl/fft_frame_loader_if.sv
// Sample-in / FFT-memory-out bundle for the frame loader.
interface fft_frame_loader_if #(
  parameter int DATA_WIDTH   = 18,
  parameter int ADDR_WIDTH   = 4,
  parameter int SAMPLE_WIDTH = 12
);
  logic                    sample_valid;
  logic [SAMPLE_WIDTH-1:0] sample_data;
  logic                    fft_done;
  logic                    mic_we;
  logic [ADDR_WIDTH-1:0]   mic_addr;
  logic [DATA_WIDTH-1:0]   mic_data;
  logic                    fft_start;
  logic                    busy;
  logic [7:0]              overrun;

  modport master (
    input  sample_valid,
    input  sample_data,
    input  fft_done,
    output mic_we,
    output mic_addr,
    output mic_data,
    output fft_start,
    output busy,
    output overrun
  );

  modport slave (
    output sample_valid,
    output sample_data,
    output fft_done,
    input  mic_we,
    input  mic_addr,
    input  mic_data,
    input  fft_start,
    input  busy,
    input  overrun
  );
endinterface

// File: rtl/fft_frame_loader.sv
// Loads ADC frames into FFT memory and kicks the FFT engine.
// Optional Hann windowing when HANN_WINDOW_EN is defined.
module fft_frame_loader #(
  parameter int DATA_WIDTH   = 18,
  parameter int ADDR_WIDTH   = 4,
  parameter int SAMPLE_WIDTH = 12,
  parameter int GAIN_SHIFT   = 4
) (
  input  logic                clk,
  input  logic                rst,
  fft_frame_loader_if.master  bus
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int SW = SAMPLE_WIDTH;
  localparam int N  = 2 ** AW;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    START,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t state, nxt;

  logic [AW-1:0]        n;
  logic                 full;
  logic                 we_q;
  logic [AW-1:0]        addr_q;
  logic signed [DW-1:0] data_q;
  logic [7:0]           ovr;

  logic accept;
  logic abort;
  logic drop;
  logic last_wr;

  logic signed [SW-1:0] centered;
  logic signed [DW-1:0] ext;
  logic signed [DW-1:0] cond;

  // Offset-binary to two's complement is an MSB flip.
  assign centered = {~bus.sample_data[SW-1],
                     bus.sample_data[SW-2:0]};
  assign ext  = {{(DW-SW){centered[SW-1]}}, centered};
  assign cond = ext <<< GAIN_SHIFT;

  assign accept = (state == FILL) && bus.fft_done
               && !full && bus.sample_valid;
  assign abort  = (state == FILL) && !bus.fft_done;
  assign drop   = bus.sample_valid && !accept;
  assign last_wr = we_q && (addr_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (bus.fft_done) nxt = FILL;
      FILL: begin
        if (!bus.fft_done) nxt = WAIT_DONE;
        else if (last_wr)  nxt = START;
      end
      START:     nxt = WAIT_ACK;
      WAIT_ACK:  if (!bus.fft_done) nxt = WAIT_DONE;
      WAIT_DONE: if (bus.fft_done) nxt = FILL;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      n    <= '0;
      full <= 1'b0;
      ovr  <= '0;
    end else begin
      if (state != FILL || abort) begin
        n    <= '0;
        full <= 1'b0;
      end else if (accept) begin
        n <= n + 1'b1;
        if (n == LAST) full <= 1'b1;
      end
      if (drop && ovr != 8'hFF) ovr <= ovr + 8'd1;
    end
  end

`ifdef HANN_WINDOW_EN
  function automatic logic signed [DW-1:0] hann(int k);
    real c;
    c = (2.0 ** (DW - 1) - 1.0) * 0.5
      * (1.0 - $cos(2.0 * 3.141592653589793 * k / N));
    return DW'($rtoi(c + 0.5));
  endfunction

  logic signed [DW-1:0]   wtab [N];
  logic                   v1;
  logic [AW-1:0]          a1;
  logic signed [DW-1:0]   d1;
  logic signed [2*DW-1:0] prod;
  logic signed [2*DW-1:0] prod_sh;

  for (genvar g = 0; g < N; g++) begin : g_w
    localparam logic signed [DW-1:0] C = hann(g);
    assign wtab[g] = C;
  end

  assign prod    = d1 * wtab[a1];
  assign prod_sh = prod >>> (DW - 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1     <= 1'b0;
      a1     <= '0;
      d1     <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a1 <= n;
        d1 <= cond;
      end
      we_q <= v1 && !abort;
      if (v1 && !abort) begin
        addr_q <= a1;
        data_q <= prod_sh[DW-1:0];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= accept;
      if (accept) begin
        addr_q <= n;
        data_q <= cond;
      end
    end
  end
`endif

  // The memory port belongs to the engine whenever fft_done is low.
  assign bus.mic_we    = we_q && bus.fft_done;
  assign bus.mic_addr  = addr_q;
  assign bus.mic_data  = data_q;
  assign bus.fft_start = (state == START);
  assign bus.busy      = (state == START)
                      || (state == WAIT_ACK)
                      || (state == WAIT_DONE);
  assign bus.overrun   = ovr;

endmodule
